// File: rtl/collatz_seq.sv
// Collatz sequence generator: emits seed, then each successor, one element per
// accepted beat until the value reaches 1 or 3n+1 no longer fits in W bits.
module collatz_seq #(
  parameter int W     = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     seed,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [CNT_W-1:0] steps,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

  state_t           state, state_n;
  logic [W-1:0]     value, value_n;
  logic [CNT_W-1:0] steps_n;
  logic [W+1:0]     trip;

  // 3*v+1 at W+2 bits so overflow out of W bits is visible in the top bits
  function automatic logic [W+1:0] triple_inc(input logic [W-1:0] v);
    logic [W+1:0] x;
    x = {2'b00, v};
    return (x << 1) + x + {{(W+1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_n = state;
    value_n = value;
    steps_n = steps;
    trip    = triple_inc(value);
    case (state)
      RUN: begin
        if (out_ready) begin
          if (value == {{(W-1){1'b0}}, 1'b1}) begin
            state_n = DONE;
          end else if (!value[0]) begin
            value_n = value >> 1;
            steps_n = sat_inc(steps);
          end else if (trip[W+1:W] != 2'b00) begin
            state_n = ERR;
          end else begin
            value_n = trip[W-1:0];
            steps_n = sat_inc(steps);
          end
        end
      end
      default: begin
        // IDLE, DONE and ERR all accept a new sequence
        if (start) begin
          steps_n = '0;
          if (seed == '0) begin
            state_n = ERR;
          end else begin
            state_n = RUN;
            value_n = seed;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      value <= '0;
      steps <= '0;
    end else begin
      state <= state_n;
      value <= value_n;
      steps <= steps_n;
    end
  end

  assign busy      = (state == RUN);
  assign done      = (state == DONE);
  assign err       = (state == ERR);
  assign out_valid = (state == RUN);
  assign out_data  = out_valid ? value : '0;

endmodule

// File: tb/tb_collatz_seq.sv
// Directed bench for collatz_seq: a W=16 instance for the main sequences and a
// W=8 instance for the overflow case.
module tb_collatz_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, ready_a, busy_a, valid_a, done_a, err_a;
  logic [15:0] seed_a, data_a;
  logic [7:0]  steps_a;
  logic        start_b, ready_b, busy_b, valid_b, done_b, err_b;
  logic [7:0]  seed_b, data_b;
  logic [7:0]  steps_b;

  int total = 0;
  int bad   = 0;

  int s6[9]   = '{6, 3, 10, 5, 16, 8, 4, 2, 1};
  int s27[12] = '{27, 82, 41, 124, 62, 31, 94, 47, 142, 71, 214, 107};

  always #5 clk = ~clk;

  collatz_seq #(.W(16), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .busy(busy_a),
    .out_valid(valid_a), .out_ready(ready_a), .out_data(data_a),
    .steps(steps_a), .done(done_a), .err(err_a)
  );

  collatz_seq #(.W(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .busy(busy_b),
    .out_valid(valid_b), .out_ready(ready_b), .out_data(data_b),
    .steps(steps_b), .done(done_b), .err(err_b)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_a(input string tag);
    chk({tag, "_busy"}, int'(busy_a), 0);
    chk({tag, "_valid"}, int'(valid_a), 0);
    chk({tag, "_data"}, int'(data_a), 0);
    chk({tag, "_steps"}, int'(steps_a), 0);
    chk({tag, "_done"}, int'(done_a), 0);
    chk({tag, "_err"}, int'(err_a), 0);
  endtask

  // Expects the first beat of seed 6 to be visible now; walks all nine beats.
  task automatic run_six(input string tag);
    for (int i = 0; i < 9; i++) begin
      chk($sformatf("%s_valid%0d", tag, i), int'(valid_a), 1);
      chk($sformatf("%s_data%0d", tag, i), int'(data_a), s6[i]);
      @(negedge clk);
    end
    chk({tag, "_done"}, int'(done_a), 1);
    chk({tag, "_steps"}, int'(steps_a), 8);
    chk({tag, "_valid_end"}, int'(valid_a), 0);
    chk({tag, "_data_end"}, int'(data_a), 0);
    chk({tag, "_busy_end"}, int'(busy_a), 0);
  endtask

  initial begin
    rst = 1'b1;
    start_a = 1'b0; seed_a = '0; ready_a = 1'b1;
    start_b = 1'b0; seed_b = '0; ready_b = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle_a("reset");
    chk("reset_b_valid", int'(valid_b), 0);
    rst = 1'b0;

    // seed 6, full-rate
    start_a = 1'b1; seed_a = 16'd6;
    @(negedge clk);
    start_a = 1'b0;
    chk("s6_busy", int'(busy_a), 1);
    run_six("s6");

    // seed 1 from DONE: one beat, no transitions
    start_a = 1'b1; seed_a = 16'd1;
    @(negedge clk);
    start_a = 1'b0;
    chk("s1_done_clr", int'(done_a), 0);
    chk("s1_valid", int'(valid_a), 1);
    chk("s1_data", int'(data_a), 1);
    @(negedge clk);
    chk("s1_done", int'(done_a), 1);
    chk("s1_steps", int'(steps_a), 0);
    chk("s1_valid_end", int'(valid_a), 0);

    // seed 0 rejected
    start_a = 1'b1; seed_a = 16'd0;
    @(negedge clk);
    start_a = 1'b0;
    chk("s0_err", int'(err_a), 1);
    chk("s0_done", int'(done_a), 0);
    chk("s0_valid", int'(valid_a), 0);
    chk("s0_data", int'(data_a), 0);
    chk("s0_steps", int'(steps_a), 0);
    chk("s0_busy", int'(busy_a), 0);

    // seed 6 from ERR with backpressure after the first beat
    start_a = 1'b1; seed_a = 16'd6;
    @(negedge clk);
    start_a = 1'b0;
    chk("bp_err_clr", int'(err_a), 0);
    chk("bp_data0", int'(data_a), 6);
    @(negedge clk);
    chk("bp_data1", int'(data_a), 3);
    ready_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold_valid%0d", i), int'(valid_a), 1);
      chk($sformatf("bp_hold_data%0d", i), int'(data_a), 3);
    end
    ready_a = 1'b1;
    @(negedge clk);
    for (int i = 2; i < 9; i++) begin
      chk($sformatf("bp_data%0d", i), int'(data_a), s6[i]);
      @(negedge clk);
    end
    chk("bp_done", int'(done_a), 1);
    chk("bp_steps", int'(steps_a), 8);

    // seed 27, ignored start in RUN, reset on 5th RUN cycle together with start
    start_a = 1'b1; seed_a = 16'd27;
    @(negedge clk);
    start_a = 1'b0;
    chk("rr_data0", int'(data_a), 27);
    @(negedge clk);
    chk("rr_data1", int'(data_a), 82);
    start_a = 1'b1; seed_a = 16'd6;
    @(negedge clk);
    start_a = 1'b0;
    chk("rr_ignored_data", int'(data_a), 41);
    chk("rr_ignored_steps", int'(steps_a), 2);
    @(negedge clk);
    chk("rr_data3", int'(data_a), 124);
    @(negedge clk);
    chk("rr_data4", int'(data_a), 62);
    rst = 1'b1; start_a = 1'b1; seed_a = 16'd5;
    @(negedge clk);
    chk_idle_a("rr_reset");
    rst = 1'b0; start_a = 1'b1; seed_a = 16'd6;
    @(negedge clk);
    start_a = 1'b0;
    run_six("rr_s6");

    // W=8: overflow at 3*107+1
    start_b = 1'b1; seed_b = 8'd27;
    @(negedge clk);
    start_b = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("ov_valid%0d", i), int'(valid_b), 1);
      chk($sformatf("ov_data%0d", i), int'(data_b), s27[i]);
      @(negedge clk);
    end
    chk("ov_err", int'(err_b), 1);
    chk("ov_done", int'(done_b), 0);
    chk("ov_valid_end", int'(valid_b), 0);
    chk("ov_data_end", int'(data_b), 0);
    chk("ov_steps", int'(steps_b), 11);
    chk("ov_busy", int'(busy_b), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
